// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Package  : clock_pkg
// Brief    : Mode encodings, BCD digit limits, display blank-mask bit indices
//            and a BCD mod-60 increment helper for the MM:SS clock.
// Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

    localparam logic [1:0] MODE_RUN     = 2'b00;
    localparam logic [1:0] MODE_SET_MIN = 2'b01;
    localparam logic [1:0] MODE_SET_SEC = 2'b10;

    localparam logic [2:0] SEC_TENS_MAX = 3'd5;
    localparam logic [3:0] UNITS_MAX    = 4'd9;

    // blank_mask bit positions, shared with the seven-segment mux
    localparam int BLANK_S2 = 0;
    localparam int BLANK_S1 = 1;
    localparam int BLANK_M2 = 2;
    localparam int BLANK_M1 = 3;

    // One two-digit BCD field (minutes or seconds), 00..59
    typedef struct packed {
        logic [2:0] tens;
        logic [3:0] units;
    } bcdPair_t;

    // BCD increment modulo 60
    function automatic bcdPair_t bcdInc(input bcdPair_t v);
        bcdPair_t r;
        r = v;
        if (v.units == UNITS_MAX) begin
            r.units = 4'd0;
            r.tens  = (v.tens == SEC_TENS_MAX) ? 3'd0 : v.tens + 3'd1;
        end else begin
            r.units = v.units + 4'd1;
        end
        return r;
    endfunction

    // True when the field reads 59, i.e. the next increment carries out
    function automatic logic bcdIsMax(input bcdPair_t v);
        return (v.tens == SEC_TENS_MAX) && (v.units == UNITS_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : 2-flop synchronizer, stable-level debounce and rising-edge
//            detector for one raw push-button; emits a one-clk press pulse.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_accepted;
    logic             r_acceptedDly;
    logic [CNT_W-1:0] r_cnt;

    // Bring the asynchronous button level into the clk domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed from the accepted one for DEBOUNCE_CYCLES clks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_accepted <= 1'b0;
        end else if (r_sync2 == r_accepted) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt      <= '0;
            r_accepted <= r_sync2;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Delayed copy of the accepted level for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acceptedDly <= 1'b0;
        end else begin
            r_acceptedDly <= r_accepted;
        end
    end

    // Both operands are registered, so the pulse is clean and exactly one clk wide
    assign press = r_accepted & ~r_acceptedDly;

endmodule
`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clock_mode_ctrl
// Brief    : MM:SS time keeping and setting controller. Advances BCD time on
//            the 1 Hz tick in RUN, edits minutes/seconds in the SET modes and
//            drives a per-digit blink mask for the display scan logic.
// Revision : 1.0 - initial release
// ============================================================================
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_clear,
    output logic [2:0] m1,
    output logic [3:0] m2,
    output logic [2:0] s1,
    output logic [3:0] s2,
    output logic [1:0] mode,
    output logic [3:0] blank_mask,
    output logic       rollover
);
    localparam int c_BTN_MODE  = 0;
    localparam int c_BTN_UP    = 1;
    localparam int c_BTN_CLEAR = 2;

    localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BLINK_W-1:0] c_BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);

    logic [2:0]         w_raw;
    logic [2:0]         w_press;
    logic               w_modePress;
    logic               w_upPress;
    logic               w_clearPress;
    logic [1:0]         r_state;
    logic [1:0]         w_nextState;
    bcdPair_t           r_min;
    bcdPair_t           r_sec;
    logic               r_rollover;
    logic [BLINK_W-1:0] r_blinkCnt;
    logic               r_blinkPhase;
    logic               w_blinkRestart;

    assign w_raw = {btn_clear, btn_up, btn_mode};

    generate
        for (genvar i = 0; i < 3; i++) begin : g_btn
            button_conditioner #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_cond (
                .clk  (clk),
                .reset(reset),
                .raw  (w_raw[i]),
                .press(w_press[i])
            );
        end
    endgenerate

    assign w_modePress  = w_press[c_BTN_MODE];
    assign w_upPress    = w_press[c_BTN_UP];
    assign w_clearPress = w_press[c_BTN_CLEAR];

    // Mode state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MODE_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Mode cycles RUN -> SET_MIN -> SET_SEC -> RUN; the unused encoding falls back to RUN
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            MODE_RUN:     if (w_modePress) w_nextState = MODE_SET_MIN;
            MODE_SET_MIN: if (w_modePress) w_nextState = MODE_SET_SEC;
            MODE_SET_SEC: if (w_modePress) w_nextState = MODE_RUN;
            default:      w_nextState = MODE_RUN;
        endcase
    end

    // Mode output and blink mask; only the field being edited blinks
    always_comb begin
        mode       = MODE_RUN;
        blank_mask = '0;
        case (r_state)
            MODE_SET_MIN: begin
                mode                 = MODE_SET_MIN;
                blank_mask[BLANK_M1] = r_blinkPhase;
                blank_mask[BLANK_M2] = r_blinkPhase;
            end
            MODE_SET_SEC: begin
                mode                 = MODE_SET_SEC;
                blank_mask[BLANK_S1] = r_blinkPhase;
                blank_mask[BLANK_S2] = r_blinkPhase;
            end
            default: begin
                mode       = MODE_RUN;
                blank_mask = '0;
            end
        endcase
    end

    // Time digits: clear beats up, up beats tick; up and tick act only in their own modes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_min      <= '0;
            r_sec      <= '0;
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= 1'b0;
            if (w_clearPress) begin
                r_min <= '0;
                r_sec <= '0;
            end else if ((r_state == MODE_SET_MIN) && w_upPress) begin
                r_min <= bcdInc(r_min);
            end else if ((r_state == MODE_SET_SEC) && w_upPress) begin
                r_sec <= bcdInc(r_sec);
            end else if ((r_state == MODE_RUN) && tick) begin
                r_sec <= bcdInc(r_sec);
                if (bcdIsMax(r_sec)) begin
                    r_min <= bcdInc(r_min);
                    if (bcdIsMax(r_min)) begin
                        r_rollover <= 1'b1;
                    end
                end
            end
        end
    end

    // Restart blinking visible on entry to a SET mode or an up press; held at zero in RUN
    assign w_blinkRestart = (w_nextState == MODE_RUN) || (w_nextState != r_state) || w_upPress;

    // Blink half-period counter and phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (w_blinkRestart) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (r_blinkCnt == c_BLINK_MAX) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= ~r_blinkPhase;
        end else begin
            r_blinkCnt <= r_blinkCnt + BLINK_W'(1);
        end
    end

    assign m1       = r_min.tens;
    assign m2       = r_min.units;
    assign s1       = r_sec.tens;
    assign s2       = r_sec.units;
    assign rollover = r_rollover;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_mode_ctrl
// Brief    : Self-checking bench for clock_mode_ctrl. A behavioural model keeps
//            time as total seconds, mode as 0..2, blink phase from the edge of
//            the last restart, and button acceptance as "raw level held for
//            DEB samples, seen two clks later".
// Revision : 1.0 - initial release
// ============================================================================
module tb_clock_mode_ctrl;

    localparam int DEB  = 4;
    localparam int BLK  = 8;
    localparam int MAXE = 20000;

    logic        clk;
    logic        reset;
    logic        tick;
    logic [2:0]  raw;
    logic [2:0]  m1;
    logic [3:0]  m2;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic [1:0]  mode;
    logic [3:0]  blank_mask;
    logic        rollover;
    logic [20:0] obs;

    int vectors;
    int miscompares;

    // reference model state
    int mdlT;
    int mdlMode;
    int mdlEdge;
    int mdlBlinkStart;
    bit mdlRoll;
    bit acc  [3];
    bit pend [3];
    bit hist [3][0:MAXE-1];

    clock_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES   (BLK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_mode  (raw[0]),
        .btn_up    (raw[1]),
        .btn_clear (raw[2]),
        .m1        (m1),
        .m2        (m2),
        .s1        (s1),
        .s2        (s2),
        .mode      (mode),
        .blank_mask(blank_mask),
        .rollover  (rollover)
    );

    assign obs = {m1, m2, s1, s2, mode, blank_mask, rollover};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mdlT = 0; mdlMode = 0; mdlEdge = 0; mdlBlinkStart = 0; mdlRoll = 0;
        for (int b = 0; b < 3; b++) begin
            acc[b] = 0; pend[b] = 0;
            for (int k = 0; k < MAXE; k++) hist[b][k] = 0;
        end
    endtask

    function automatic bit histAt(int b, int k);
        if (k < 1 || k >= MAXE) return 1'b0;
        return hist[b][k];
    endfunction

    // One active clk edge of the reference model
    task automatic model_edge();
        bit pm, pu, pc, flip;
        int mins, secs, nm;
        mdlEdge++;
        pm = pend[0]; pu = pend[1]; pc = pend[2];
        mins = mdlT / 60; secs = mdlT % 60;
        mdlRoll = 0;
        if (pc) mdlT = 0;
        else if (mdlMode == 1 && pu) mdlT = ((mins + 1) % 60) * 60 + secs;
        else if (mdlMode == 2 && pu) mdlT = mins * 60 + (secs + 1) % 60;
        else if (mdlMode == 0 && tick) begin
            if (mdlT == 3599) begin mdlT = 0; mdlRoll = 1; end
            else mdlT = mdlT + 1;
        end
        nm = pm ? (mdlMode + 1) % 3 : mdlMode;
        if (nm == 0 || nm != mdlMode || pu) mdlBlinkStart = mdlEdge;
        mdlMode = nm;
        for (int b = 0; b < 3; b++) begin
            if (mdlEdge < MAXE) hist[b][mdlEdge] = raw[b];
            flip = 1;
            for (int k = mdlEdge - DEB - 1; k <= mdlEdge - 2; k++)
                if (histAt(b, k) == acc[b]) flip = 0;
            pend[b] = 0;
            if (flip) begin acc[b] = !acc[b]; pend[b] = acc[b]; end
        end
    endtask

    function automatic logic [20:0] expVec();
        int mins, secs;
        bit ph;
        logic [3:0] bm;
        mins = mdlT / 60; secs = mdlT % 60;
        ph = (((mdlEdge - mdlBlinkStart) / BLK) % 2) == 1;
        bm = 4'b0000;
        if (mdlMode == 1 && ph) bm = 4'b1100;
        if (mdlMode == 2 && ph) bm = 4'b0011;
        return {3'(mins / 10), 4'(mins % 10), 3'(secs / 10), 4'(secs % 10), 2'(mdlMode), bm, mdlRoll};
    endfunction

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) step();
    endtask

    task automatic pressBtn(int b, int hold);
        raw[b] = 1'b1;
        idle(hold);
        raw[b] = 1'b0;
        idle(DEB + 4);
    endtask

    // From RUN: clear, load minutes then seconds, return to RUN
    task automatic setTime(int mins, int secs);
        pressBtn(0, 6);
        pressBtn(2, 6);
        repeat (mins) pressBtn(1, 6);
        pressBtn(0, 6);
        repeat (secs) pressBtn(1, 6);
        pressBtn(0, 6);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b0; raw = 3'b000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (obs !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_values: got %h expected %h", obs, 21'd0);
        end
        #2 reset = 1'b0;
        idle(3);
        vectors++;
        if (obs !== expVec()) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", obs, expVec());
        end
    endtask

    task automatic test_async_reset();
        setTime(12, 34);
        vectors++;
        if (obs[20:7] !== {3'd1, 4'd2, 3'd3, 4'd4}) begin
            miscompares++;
            $display("FAIL preload_12_34: got %h expected %h", obs[20:7], {3'd1, 4'd2, 3'd3, 4'd4});
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (obs !== 21'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs, 21'd0);
        end
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        idle(2);
        vectors++;
        if (obs !== expVec()) begin
            miscompares++;
            $display("FAIL after_async_reset: got %h expected %h", obs, expVec());
        end
    endtask

    task automatic test_run_carry();
        setTime(0, 59);
        tick = 1'b1; step(); tick = 1'b0;
        vectors++;
        if (obs !== {3'd0, 4'd1, 3'd0, 4'd0, 2'b00, 4'b0000, 1'b0} || obs !== expVec()) begin
            miscompares++;
            $display("FAIL carry_00_59: got %h expected %h", obs, expVec());
        end
        setTime(59, 59);
        tick = 1'b1; step(); tick = 1'b0;
        vectors++;
        if (obs[20:7] !== 14'd0 || rollover !== 1'b1 || obs !== expVec()) begin
            miscompares++;
            $display("FAIL wrap_59_59: got %h expected %h", obs, expVec());
        end
        step();
        vectors++;
        if (rollover !== 1'b0 || obs !== expVec()) begin
            miscompares++;
            $display("FAIL rollover_one_clk: got %h expected %h", obs, expVec());
        end
    endtask

    task automatic test_debounce();
        pressBtn(0, 6);
        pressBtn(2, 6);
        repeat (5) begin
            raw[1] = 1'b1; idle(2);
            raw[1] = 1'b0; idle(3);
        end
        idle(8);
        vectors++;
        if (obs[20:14] !== 7'd0 || obs !== expVec()) begin
            miscompares++;
            $display("FAIL glitch_rejected: got %h expected %h", obs, expVec());
        end
        raw[1] = 1'b1;
        idle(10);
        vectors++;
        if (obs[20:14] !== {3'd0, 4'd1} || obs !== expVec()) begin
            miscompares++;
            $display("FAIL clean_press: got %h expected %h", obs, expVec());
        end
        idle(100);
        raw[1] = 1'b0;
        idle(10);
        vectors++;
        if (obs[20:14] !== {3'd0, 4'd1} || obs !== expVec()) begin
            miscompares++;
            $display("FAIL held_no_repeat: got %h expected %h", obs, expVec());
        end
        pressBtn(0, 6);
        pressBtn(0, 6);
    endtask

    task automatic test_mode_blink();
        logic [1:0] want;
        for (int p = 0; p < 3; p++) begin
            raw[0] = 1'b1;
            for (int i = 0; i < 40; i++) begin
                if (i == 6) raw[0] = 1'b0;
                step();
                vectors++;
                if (obs !== expVec()) begin
                    miscompares++;
                    $display("FAIL mode_blink p%0d c%0d: got %h expected %h", p, i, obs, expVec());
                end
            end
            want = 2'((p + 1) % 3);
            vectors++;
            if (mode !== want) begin
                miscompares++;
                $display("FAIL mode_sequence: got %b expected %b", mode, want);
            end
        end
    endtask

    task automatic test_set_wrap();
        setTime(7, 59);
        pressBtn(0, 6);
        pressBtn(0, 6);
        tick = 1'b1;
        pressBtn(1, 6);
        idle(20);
        tick = 1'b0;
        vectors++;
        if (obs[20:7] !== {3'd0, 4'd7, 3'd0, 4'd0} || mode !== 2'b10 || obs !== expVec()) begin
            miscompares++;
            $display("FAIL set_sec_wrap_freeze: got %h expected %h", obs, expVec());
        end
        pressBtn(0, 6);
    endtask

    task automatic test_priority();
        setTime(5, 5);
        pressBtn(0, 6);
        raw[2:1] = 2'b11;
        idle(6);
        raw[2:1] = 2'b00;
        idle(DEB + 4);
        vectors++;
        if (obs[20:7] !== 14'd0 || mode !== 2'b01 || obs !== expVec()) begin
            miscompares++;
            $display("FAIL clear_beats_up: got %h expected %h", obs, expVec());
        end
        pressBtn(0, 6);
        pressBtn(0, 6);
        setTime(59, 59);
        raw[2] = 1'b1;
        idle(DEB + 2);
        tick = 1'b1; step(); tick = 1'b0;
        vectors++;
        if (obs[20:7] !== 14'd0 || rollover !== 1'b0 || obs !== expVec()) begin
            miscompares++;
            $display("FAIL clear_beats_tick: got %h expected %h", obs, expVec());
        end
        raw[2] = 1'b0;
        idle(DEB + 4);
    endtask

    task automatic test_random();
        int dur [3];
        for (int b = 0; b < 3; b++) dur[b] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                dur[b]--;
                if (dur[b] <= 0) begin
                    raw[b] = 1'($urandom_range(0, 1));
                    dur[b] = $urandom_range(1, 12);
                end
            end
            tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 799) == 0) begin
                #2 reset = 1'b1;
                model_reset();
                @(posedge clk);
                #2 reset = 1'b0;
            end
            step();
            vectors++;
            if (obs !== expVec()) begin
                miscompares++;
                $display("FAIL random c%0d: got %h expected %h", c, obs, expVec());
            end
        end
        tick = 1'b0; raw = 3'b000;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_async_reset();
        test_run_carry();
        test_debounce();
        test_mode_blink();
        test_set_wrap();
        test_priority();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
